// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int NUM_REQ  = 2;
  localparam int READ_LAT = 2;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 8;

  typedef enum logic {
    PRI_R0 = 1'b0,
    PRI_R1 = 1'b1
  } pri_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_cmd_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/ram_arbiter_rr_grant2.sv
// Two-input round-robin grant. Combinational grant, registered priority pointer
// that moves to the losing side on every accepted command.
module rr_grant2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  pri_t ptr;
  pri_t ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PRI_R0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

  always_comb begin
    gnt     = req;
    ptr_nxt = ptr;
    if (req == 2'b11) begin
      gnt = (ptr == PRI_R1) ? 2'b10 : 2'b01;
    end
    if (accept) begin
      ptr_nxt = gnt[0] ? PRI_R1 : PRI_R0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two requesters; all RAM pins
// are registered and reads return on a fixed two-cycle RVALID pulse.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDRWIDTH = ADDR_W,
  parameter int DATAWIDTH = DATA_W
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 WE0,
  input  logic [ADDRWIDTH-1:0] ADDR0,
  input  logic [DATAWIDTH-1:0] WDATA0,
  output logic                 ACK0,
  output logic                 RVALID0,
  output logic [DATAWIDTH-1:0] RDATA0,
  input  logic                 REQ1,
  input  logic                 WE1,
  input  logic [ADDRWIDTH-1:0] ADDR1,
  input  logic [DATAWIDTH-1:0] WDATA1,
  output logic                 ACK1,
  output logic                 RVALID1,
  output logic [DATAWIDTH-1:0] RDATA1,
  output logic [ADDRWIDTH-1:0] RAM_A,
  output logic                 RAM_WE,
  output logic                 RAM_OE,
  output logic [DATAWIDTH-1:0] RAM_D,
  input  logic [DATAWIDTH-1:0] RAM_Q
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               accept;
  req_cmd_t           cmd0;
  req_cmd_t           cmd1;
  req_cmd_t           cmd;
  rd_tag_t            tag_in;
  rd_tag_t            tag_pipe [READ_LAT];
  rd_tag_t            tag_out;

  // Requests are masked in reset so no grant can be seen while RST is high.
  assign req    = {REQ1, REQ0} & {NUM_REQ{~RST}};
  assign accept = |(req & gnt);
  assign ACK0   = gnt[0];
  assign ACK1   = gnt[1];

  rr_grant2 u_grant (
    .clk    (CK),
    .rst    (RST),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign cmd0 = '{we: WE0, addr: ADDR0, wdata: WDATA0};
  assign cmd1 = '{we: WE1, addr: ADDR1, wdata: WDATA1};
  assign cmd  = gnt[1] ? cmd1 : cmd0;

  assign tag_in  = '{valid: accept & ~cmd.we, id: gnt[1]};
  assign tag_out = tag_pipe[READ_LAT-1];

  always_ff @(posedge CK) begin
    if (RST) begin
      RAM_A  <= '0;
      RAM_WE <= 1'b0;
      RAM_D  <= '0;
      RAM_OE <= 1'b0;
    end else begin
      RAM_OE <= 1'b1;
      if (accept) begin
        RAM_A  <= cmd.addr;
        RAM_WE <= cmd.we;
        if (cmd.we) begin
          RAM_D <= cmd.wdata;
        end
      end else begin
        RAM_WE <= 1'b0;
      end
    end
  end

  // Tag pipeline tracks which requester owns the RAM_Q word arriving READ_LAT later.
  always_ff @(posedge CK) begin
    if (RST) begin
      for (int i = 0; i < READ_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      RDATA0  <= '0;
      RDATA1  <= '0;
    end else begin
      RVALID0 <= tag_out.valid & ~tag_out.id;
      RVALID1 <= tag_out.valid & tag_out.id;
      if (tag_out.valid && !tag_out.id) begin
        RDATA0 <= RAM_Q;
      end
      if (tag_out.valid && tag_out.id) begin
        RDATA1 <= RAM_Q;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized + directed bench for ram_arbiter with a behavioural RAM and a
// scoreboard of expected read returns.
module tb_ram_arbiter;

  logic        CK;
  logic        RST;
  logic        REQ0, WE0, ACK0, RVALID0;
  logic [11:0] ADDR0;
  logic [7:0]  WDATA0, RDATA0;
  logic        REQ1, WE1, ACK1, RVALID1;
  logic [11:0] ADDR1;
  logic [7:0]  WDATA1, RDATA1;
  logic [11:0] RAM_A;
  logic        RAM_WE, RAM_OE;
  logic [7:0]  RAM_D, RAM_Q;

  ram_arbiter dut (
    .CK(CK), .RST(RST),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0),
    .ACK0(ACK0), .RVALID0(RVALID0), .RDATA0(RDATA0),
    .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1),
    .ACK1(ACK1), .RVALID1(RVALID1), .RDATA1(RDATA1),
    .RAM_A(RAM_A), .RAM_WE(RAM_WE), .RAM_OE(RAM_OE), .RAM_D(RAM_D),
    .RAM_Q(RAM_Q)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Behavioural single-port synchronous RAM.
  logic [7:0] ram [4096];
  always @(posedge CK) begin
    if (RAM_WE) ram[RAM_A] <= RAM_D;
    RAM_Q <= ram[RAM_A];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: memory contents in command order, priority owner,
  // expected pin state and a queue of pending read returns.
  typedef struct {
    int         id;
    logic [7:0] data;
    int         due;
  } sb_t;

  sb_t        sb [$];
  logic [7:0] model_mem [4096];
  int         pri = 0;
  logic [11:0] exp_a  = '0;
  logic        exp_we = 1'b0;
  logic [7:0]  exp_d  = '0;
  logic        exp_oe = 1'b0;
  logic [7:0]  exp_rd [2] = '{8'h00, 8'h00};

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]       = 8'h00;
      model_mem[i] = 8'h00;
    end
  end

  always @(negedge CK) begin
    logic ev0, ev1, ea0, ea1, acc_we;
    int acc_id;
    logic [11:0] acc_a;
    logic [7:0]  acc_d;

    ev0 = 1'b0;
    ev1 = 1'b0;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("read_lost", 32'(sb[0].due), 32'(cyc));
      sb.pop_front();
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      if (sb[0].id == 1) ev1 = 1'b1; else ev0 = 1'b1;
      exp_rd[sb[0].id] = sb[0].data;
      sb.pop_front();
    end
    chk("rvalid0", 32'(RVALID0), 32'(ev0));
    chk("rvalid1", 32'(RVALID1), 32'(ev1));
    chk("rdata0", 32'(RDATA0), 32'(exp_rd[0]));
    chk("rdata1", 32'(RDATA1), 32'(exp_rd[1]));
    chk("ram_a", 32'(RAM_A), 32'(exp_a));
    chk("ram_we", 32'(RAM_WE), 32'(exp_we));
    chk("ram_d", 32'(RAM_D), 32'(exp_d));
    chk("ram_oe", 32'(RAM_OE), 32'(exp_oe));

    ea0 = 1'b0;
    ea1 = 1'b0;
    if (RST !== 1'b1) begin
      if (REQ0 && REQ1) begin
        if (pri == 0) ea0 = 1'b1; else ea1 = 1'b1;
      end else begin
        ea0 = REQ0;
        ea1 = REQ1;
      end
    end
    chk("ack0", 32'(ACK0), 32'(ea0));
    chk("ack1", 32'(ACK1), 32'(ea1));

    if (RST === 1'b1) begin
      sb.delete();
      pri    = 0;
      exp_a  = '0;
      exp_we = 1'b0;
      exp_d  = '0;
      exp_oe = 1'b0;
      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
    end else begin
      exp_oe = 1'b1;
      if (ea0 || ea1) begin
        acc_id = ea1 ? 1 : 0;
        acc_we = ea1 ? WE1 : WE0;
        acc_a  = ea1 ? ADDR1 : ADDR0;
        acc_d  = ea1 ? WDATA1 : WDATA0;
        exp_a  = acc_a;
        exp_we = acc_we;
        if (acc_we) begin
          exp_d = acc_d;
          model_mem[acc_a] = acc_d;
        end else begin
          sb.push_back('{id: acc_id, data: model_mem[acc_a], due: cyc + 3});
        end
        pri = 1 - acc_id;
      end else begin
        exp_we = 1'b0;
      end
    end
  end

  task automatic drive(input int id, input logic req, input logic we,
                       input logic [11:0] a, input logic [7:0] d);
    if (id == 0) begin
      REQ0 = req; WE0 = we; ADDR0 = a; WDATA0 = d;
    end else begin
      REQ1 = req; WE1 = we; ADDR1 = a; WDATA1 = d;
    end
  endtask

  // Issue one command and hold it until accepted; returns just after the accept edge.
  task automatic cmd(input int id, input logic we, input logic [11:0] a, input logic [7:0] d);
    logic got;
    got = 1'b0;
    drive(id, 1'b1, we, a, d);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CK);
      got = (id == 0) ? ACK0 : ACK1;
    end
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
    @(posedge CK);
    #1;
    drive(id, 1'b0, we, a, d);
  endtask

  // Both requesters issue one command each, released individually on accept.
  task automatic pair(input logic we0, input logic [11:0] a0, input logic [7:0] d0,
                      input logic we1, input logic [11:0] a1, input logic [7:0] d1);
    logic g0, g1, done0, done1;
    done0 = 1'b0;
    done1 = 1'b0;
    drive(0, 1'b1, we0, a0, d0);
    drive(1, 1'b1, we1, a1, d1);
    for (int k = 0; k < 20 && !(done0 && done1); k++) begin
      @(negedge CK);
      g0 = ACK0;
      g1 = ACK1;
      @(posedge CK);
      #1;
      if (g0) begin done0 = 1'b1; REQ0 = 1'b0; end
      if (g1) begin done1 = 1'b1; REQ1 = 1'b0; end
    end
    if (!(done0 && done1)) chk("pair_timeout", 32'({done0, done1}), 32'd3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    idle(n);
    RST = 1'b0;
  endtask

  initial begin
    logic [11:0] region;
    RST = 1'b1;
    drive(0, 1'b0, 1'b0, 12'h000, 8'h00);
    drive(1, 1'b0, 1'b0, 12'h000, 8'h00);
    idle(3);
    RST = 1'b0;
    idle(4);

    // Single write then read by R0.
    cmd(0, 1'b1, 12'h123, 8'hA5);
    cmd(0, 1'b0, 12'h123, 8'h00);
    idle(4);

    // Contention: preload, then both hold reads for six cycles.
    cmd(0, 1'b1, 12'h010, 8'h11);
    cmd(1, 1'b1, 12'h020, 8'h22);
    drive(0, 1'b1, 1'b0, 12'h010, 8'h00);
    drive(1, 1'b1, 1'b0, 12'h020, 8'h00);
    idle(6);
    drive(0, 1'b0, 1'b0, 12'h010, 8'h00);
    drive(1, 1'b0, 1'b0, 12'h020, 8'h00);
    idle(4);

    // Back-to-back read-after-write, then a mixed pair.
    cmd(1, 1'b1, 12'h7FF, 8'h3C);
    cmd(1, 1'b0, 12'h7FF, 8'h00);
    cmd(1, 1'b1, 12'hFFF, 8'h00);
    pair(1'b1, 12'h000, 8'hFF, 1'b0, 12'hFFF, 8'h00);
    idle(4);

    // Reset right after accepting a read: it must never return.
    cmd(0, 1'b0, 12'h123, 8'h00);
    do_reset(2);
    idle(2);
    cmd(0, 1'b0, 12'h123, 8'h00);
    idle(4);

    // Reset right after accepting a write: the write still lands.
    cmd(1, 1'b1, 12'h055, 8'h99);
    do_reset(2);
    idle(2);
    cmd(0, 1'b0, 12'h055, 8'h00);
    idle(4);

    // Random traffic, fields free to change while unaccepted, rare resets.
    for (int c = 0; c < 600; c++) begin
      for (int id = 0; id < 2; id++) begin
        region = 12'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) region = 12'($urandom);
        drive(id, ($urandom_range(0, 3) != 0), 1'($urandom), region, 8'($urandom));
      end
      RST = ($urandom_range(0, 149) == 0);
      idle(1);
    end
    RST = 1'b0;
    drive(0, 1'b0, 1'b0, 12'h000, 8'h00);
    drive(1, 1'b0, 1'b0, 12'h000, 8'h00);
    idle(6);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer that shares one single-port synchronous RAM between two requesters (R0, R1).
- Each requester uses a valid/ready handshake for commands. Read data returns on a fixed-latency RVALID pulse.
- Sits between the RAM and the lab datapath engines. All RAM pins are driven from registers inside this block.

Parameters:
ADDRWIDTH, 12, RAM address width (RAM depth 2^ADDRWIDTH)
DATAWIDTH, 8, RAM data width

Ports:
CK  input  1  clock; all logic on posedge; RAM shares this clock
RST  input  1  synchronous, active-high reset
REQ0  input  1  R0 command valid; command fields held stable until accepted
WE0  input  1  R0 command: 1 = write, 0 = read
ADDR0  input  ADDRWIDTH  R0 address
WDATA0  input  DATAWIDTH  R0 write data
ACK0  output  1  R0 ready (combinational grant); accepted when REQ0&ACK0 at posedge
RVALID0  output  1  one-cycle pulse, RDATA0 valid
RDATA0  output  DATAWIDTH  R0 read data
REQ1, WE1, ADDR1, WDATA1, ACK1, RVALID1, RDATA1: same as R0, for requester 1
RAM_A  output  ADDRWIDTH  RAM address (registered)
RAM_WE  output  1  RAM write enable (registered)
RAM_OE  output  1  RAM output enable (registered)
RAM_D  output  DATAWIDTH  RAM write data (registered)
RAM_Q  input  DATAWIDTH  RAM read data

Behaviour:
- Reset values (while RST is sampled high): RAM_A=0, RAM_WE=0, RAM_D=0, RAM_OE=0, RVALID0/1=0, RDATA0/1=0, priority pointer = R0, read-tag pipeline cleared.
  - RAM_OE goes to 1 at the first posedge with RST=0 and stays at 1.
  - ACKx is 0 while RST=1.
- Grant rule (combinational):
  - Only one requester active: it gets ACK.
  - Both active: the requester named by the priority pointer gets ACK; the other sees ACK=0.
  - At most one ACK is high in any cycle.
- Pointer update: on each accepted command, the pointer moves to the requester that was not granted. With no acceptance, the pointer holds. Continuous requests from both sides therefore alternate R0, R1, R0, …
- Acceptance (posedge N with REQx&ACKx):
  - RAM_A <= ADDRx.
  - RAM_WE <= WEx.
  - RAM_D <= WDATAx for a write; for a read, RAM_D holds its previous value.
  - No acceptance at posedge N: RAM_WE <= 0; RAM_A and RAM_D hold.
- RAM timing:
  - The RAM samples A/WE/D at posedge N+1 and writes at that edge.
  - For a read, RAM_Q is valid after negedge N+1.
- Read return:
  - A 2-stage tag pipeline carries {is_read, requester id}.
  - At posedge N+2, RDATAx <= RAM_Q and RVALIDx <= 1 for exactly one cycle, for the owning requester only.
  - Fixed read latency is 2 cycles from acceptance to the RVALID edge.
  - RDATAx holds its value when RVALIDx=0.
- Writes produce no RVALID.
- Throughput: one command per cycle, with back-to-back reads and writes in any mix. RVALID0 and RVALID1 are never high in the same cycle.
- Read-after-write to the same address, accepted in consecutive cycles, returns the new data (the write commits at the earlier RAM edge).
- Address wrap: addresses are used as-is with no increment logic. Out-of-range addresses cannot occur because of the width.
- Reset mid-operation:
  - A write registered onto the RAM pins before the reset edge still commits, because the RAM samples the old RAM_WE at that edge.
  - In-flight reads are discarded: the tag pipeline is cleared and no RVALID is produced.
  - A requester holding REQ through reset is serviced after reset, with R0 first.
- A requester that drops REQ without ACK has no effect. Command fields changing while REQ=1 and ACK=0 are legal; the values present at the accepting edge are used.

Decomposition:
- Shared package ram_arb_pkg holds:
  - constants NUM_REQ=2 and READ_LAT=2;
  - typedef req_cmd_t {we, addr, wdata};
  - typedef rd_tag_t {valid, id}.
- Natural sub-module rr_grant2: two-input round-robin grant with pointer register. Inputs are req[1:0] and accept; outputs are gnt[1:0]. It is instantiated once. Datapath registers and the tag pipeline stay in ram_arbiter.

Test Plan:
- Reset and idle: hold RST 3 cycles, then release with no REQ → all outputs 0 during reset; RAM_OE=1 one cycle after release; RAM_WE stays 0.
- Single write then read by R0: write ADDR0=0x123, WDATA0=0xA5, then read 0x123 → ACK0 high in both cycles; RVALID0 pulses 2 cycles after read acceptance with RDATA0=0xA5; RVALID1 stays 0.
- Contention:
  - Stimulus: both requesters hold reads for 6 cycles; R0 targets 0x010, R1 targets 0x020, both preloaded, 0x11 and 0x22.
  - Response: ACK alternates R0, R1, R0, …; RVALID0 and RVALID1 alternate, with RDATA0=0x11 and RDATA1=0x22; the two RVALIDs never overlap.
- Back-to-back read-after-write: R1 writes 0x7FF=0x3C, then reads 0x7FF in the next cycle → RDATA1=0x3C. Then R0 writes 0x000=0xFF while R1 reads 0xFFF=0x00 preload → data is routed to the correct requester.
- Reset mid-read: accept an R0 read, then assert RST on the next edge → no RVALID0. Re-read the same address after reset → correct data.
- Reset right after a write: accept R1 write 0x055=0x99, then assert RST on the next edge → after reset, reading 0x055 returns 0x99.
